// File: rtl/clock_pkg.sv
// Shared constants, widths and state encoding for the digital clock.
// Also holds the wrap-around increment helpers used by the time editor.
package clock_pkg;

    localparam int HOURS_W     = 5;
    localparam int MINUTES_W   = 7;
    localparam int HOURS_MAX   = 23;
    localparam int MINUTES_MAX = 59;

    localparam logic [1:0] FIELD_NONE    = 2'd0;
    localparam logic [1:0] FIELD_HOURS   = 2'd1;
    localparam logic [1:0] FIELD_MINUTES = 2'd2;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        EDIT_HR  = 2'd1,
        EDIT_MIN = 2'd2,
        COMMIT   = 2'd3
    } set_state_t;

    // Out-of-range values collapse to 0 as well as the normal wrap.
    function automatic logic [HOURS_W-1:0] inc_hours(
        input logic [HOURS_W-1:0] h
    );
        if (h >= HOURS_W'(HOURS_MAX))
            return '0;
        return h + 1'b1;
    endfunction

    function automatic logic [MINUTES_W-1:0] inc_minutes(
        input logic [MINUTES_W-1:0] m
    );
        if (m >= MINUTES_W'(MINUTES_MAX))
            return '0;
        return m + 1'b1;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus counting debouncer for one raw button.
// Emits a one-cycle press pulse on each debounced rising edge.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level_q;
    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            press   <= 1'b0;
            count   <= '0;
        end else begin
            sync1   <= btn_raw;
            sync2   <= sync1;
            level_q <= level;
            press   <= level & ~level_q;
            if (sync2 == level) begin
                count <= '0;
            end else if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= ~level;
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/time_set_controller.sv
// Button-driven hour/minute editor that loads the clock counters
// through a one-cycle set strobe.
module time_set_controller
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 btn_mode,
    input  logic                 btn_inc,
    input  logic [HOURS_W-1:0]   cur_hours,
    input  logic [MINUTES_W-1:0] cur_minutes,
    output logic                 set,
    output logic [HOURS_W-1:0]   set_hours,
    output logic [MINUTES_W-1:0] set_minutes,
    output logic [1:0]           edit_field
);

    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    set_state_t    state;
    set_state_t    state_next;
    logic          mode_ev;
    logic          inc_ev;
    logic          editing;
    logic          timeout;
    logic [IW-1:0] idle;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_mode (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_mode),
        .level  (),
        .press  (mode_ev)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_inc (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_inc),
        .level  (),
        .press  (inc_ev)
    );

    assign editing = (state == EDIT_HR) || (state == EDIT_MIN);
    // A press on the final idle cycle keeps the edit alive.
    assign timeout = editing && !inc_ev
                   && (idle == IW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset)
            state <= RUN;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            RUN: begin
                if (mode_ev)
                    state_next = EDIT_HR;
            end
            EDIT_HR: begin
                if (mode_ev)
                    state_next = EDIT_MIN;
                else if (timeout)
                    state_next = RUN;
            end
            EDIT_MIN: begin
                if (mode_ev)
                    state_next = COMMIT;
                else if (timeout)
                    state_next = RUN;
            end
            COMMIT: state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        set        = 1'b0;
        edit_field = FIELD_NONE;
        unique case (state)
            EDIT_HR:  edit_field = FIELD_HOURS;
            EDIT_MIN: edit_field = FIELD_MINUTES;
            COMMIT:   set        = 1'b1;
            default:  edit_field = FIELD_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idle <= '0;
        end else if (!editing || mode_ev || inc_ev
                     || state_next != state) begin
            idle <= '0;
        end else begin
            idle <= idle + 1'b1;
        end
    end

    // Mode has priority: an inc in the same cycle is dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            set_hours   <= '0;
            set_minutes <= '0;
        end else if (mode_ev) begin
            if (state == RUN) begin
                set_hours   <= cur_hours;
                set_minutes <= cur_minutes;
            end
        end else if (inc_ev) begin
            if (state == EDIT_HR)
                set_hours <= inc_hours(set_hours);
            else if (state == EDIT_MIN)
                set_minutes <= inc_minutes(set_minutes);
        end
    end

endmodule

// File: tb/tb_time_set_controller.sv
// Scoreboard bench: expected set loads are queued by the stimulus
// and checked by a monitor whenever the DUT strobes set.
module tb_time_set_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [4:0] cur_hours = '0;
    logic [6:0] cur_minutes = '0;
    logic       set;
    logic [4:0] set_hours;
    logic [6:0] set_minutes;
    logic [1:0] edit_field;

    int checks = 0;
    int passes = 0;
    int inc_presses = 0;

    typedef struct {
        int hours;
        int minutes;
    } load_t;

    load_t exp_q[$];

    time_set_controller #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .cur_hours  (cur_hours),
        .cur_minutes(cur_minutes),
        .set        (set),
        .set_hours  (set_hours),
        .set_minutes(set_minutes),
        .edit_field (edit_field)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dut.u_inc.press === 1'b1)
            inc_presses++;
    end

    // Monitor: every set strobe must match the head of the queue.
    always @(negedge clk) begin
        if (set === 1'b1) begin
            load_t e;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_set: got %0d:%0d, none expected",
                         set_hours, set_minutes);
            end else begin
                e = exp_q.pop_front();
                if (set_hours == e.hours && set_minutes == e.minutes)
                    passes++;
                else
                    $display("FAIL set_load: got %0d:%0d, expected %0d:%0d",
                             set_hours, set_minutes, e.hours, e.minutes);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp)
            passes++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic press_btn(input bit m, input bit i);
        btn_mode = m;
        btn_inc  = i;
        tick(10);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        tick(10);
    endtask

    initial begin
        int first;
        int entry;

        // Reset held with buttons chattering
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            btn_mode = ~btn_mode;
            btn_inc  = ~btn_inc;
            tick(1);
        end
        check("rst_set", set, 0);
        check("rst_hours", set_hours, 0);
        check("rst_minutes", set_minutes, 0);
        check("rst_field", edit_field, 0);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        reset    = 1'b1;
        tick(20);

        // Bounce on inc, ending with a steady high
        inc_presses = 0;
        for (int i = 0; i < 10; i++) begin
            btn_inc = ~btn_inc;
            tick(2);
        end
        btn_inc = 1'b1;
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            if (dut.u_inc.press === 1'b1 && first == 0)
                first = k;
        end
        btn_inc = 1'b0;
        tick(12);
        check("bounce_count", inc_presses, 1);
        check("bounce_latency", first, 7);
        check("bounce_run_field", edit_field, 0);

        // Full edit 22:58 -> 01:02
        cur_hours   = 5'd22;
        cur_minutes = 7'd58;
        press_btn(1, 0);
        check("edit_field_hr", edit_field, 1);
        check("load_hours", set_hours, 22);
        check("load_minutes", set_minutes, 58);
        repeat (3) press_btn(0, 1);
        check("wrap_hours", set_hours, 1);
        press_btn(1, 0);
        check("edit_field_min", edit_field, 2);
        repeat (4) press_btn(0, 1);
        check("wrap_minutes", set_minutes, 2);
        exp_q.push_back('{hours: 1, minutes: 2});
        press_btn(1, 0);
        check("edit_field_done", edit_field, 0);
        check("held_hours", set_hours, 1);
        check("held_minutes", set_minutes, 2);

        // Timeout from EDIT_HR
        cur_hours   = 5'd10;
        cur_minutes = 7'd20;
        btn_mode = 1'b1;
        entry = 0;
        for (int k = 1; k <= 30 && entry == 0; k++) begin
            tick(1);
            if (edit_field == 2'd1)
                entry = k;
        end
        btn_mode = 1'b0;
        check("timeout_entry", (entry != 0) ? 1 : 0, 1);
        tick(59);
        check("timeout_before", edit_field, 1);
        tick(7);
        check("timeout_after", edit_field, 0);
        check("timeout_hours", set_hours, 10);

        // Simultaneous mode and inc in EDIT_HR
        cur_hours   = 5'd3;
        cur_minutes = 7'd7;
        press_btn(1, 0);
        press_btn(0, 1);
        press_btn(0, 1);
        check("sim_pre_hours", set_hours, 5);
        press_btn(1, 1);
        check("sim_field", edit_field, 2);
        check("sim_hours", set_hours, 5);
        check("sim_minutes", set_minutes, 7);

        // Reset while in EDIT_MIN
        reset = 1'b0;
        tick(1);
        check("midrst_field", edit_field, 0);
        check("midrst_hours", set_hours, 0);
        check("midrst_minutes", set_minutes, 0);
        reset = 1'b1;
        tick(20);

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
